// File: rtl/count_bcd_display_if.sv
// Bundles the value input and the converted/display outputs of count_bcd_display.
// The master side drives count; the slave side (the display stage) drives the rest.
interface count_bcd_display_if;
  logic [7:0]  count;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (output count, input bcd, bcd_valid, busy, seg, an);
  modport slave  (input count, output bcd, bcd_valid, busy, seg, an);
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD display stage: a free-running double-dabble converter feeding a
// time-multiplexed 3-digit 7-segment scan with leading-zero blanking.
module count_bcd_display #(
  parameter int REFRESH_DIV  = 16,
  parameter bit COMMON_ANODE = 1'b1
) (
  input logic               clk,
  input logic               reset,
  count_bcd_display_if.slave bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SHIFT  = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [1:0]  r_state;
  logic [19:0] r_sr;
  logic [2:0]  r_iter;
  logic [11:0] r_bcd;
  logic        r_bcd_valid;
  logic [15:0] r_refresh;
  logic [1:0]  r_digit;
  logic [6:0]  r_seg;
  logic [2:0]  r_an;

  logic [19:0] w_adj;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_hi;
  logic [2:0]  w_an_hi;

  // Add-3 correction on each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign w_adj[8+4*gi +: 4] = (r_sr[8+4*gi +: 4] >= 4'd5) ?
                                  (r_sr[8+4*gi +: 4] + 4'd3) : r_sr[8+4*gi +: 4];
    end
  endgenerate
  assign w_adj[7:0] = r_sr[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_iter      <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sr    <= {12'h000, bus.count};
          r_iter  <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_sr   <= {w_adj[18:0], 1'b0};
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd       <= r_sr[19:8];
          r_bcd_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Select the scanned nibble and decide whether it is a leading zero.
  always_comb begin
    w_nib   = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_digit)
      2'd1: begin
        w_nib   = r_bcd[7:4];
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib   = r_bcd[11:8];
        w_blank = (r_bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_seg_hi = 7'h00;
    case (w_nib)
      4'd0: w_seg_hi = 7'h3F;
      4'd1: w_seg_hi = 7'h06;
      4'd2: w_seg_hi = 7'h5B;
      4'd3: w_seg_hi = 7'h4F;
      4'd4: w_seg_hi = 7'h66;
      4'd5: w_seg_hi = 7'h6D;
      4'd6: w_seg_hi = 7'h7D;
      4'd7: w_seg_hi = 7'h07;
      4'd8: w_seg_hi = 7'h7F;
      4'd9: w_seg_hi = 7'h6F;
      default: w_seg_hi = 7'h00;
    endcase
    if (w_blank) w_seg_hi = 7'h00;
  end

  assign w_an_hi = w_blank ? 3'b000 : (3'b001 << r_digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_seg     <= {7{COMMON_ANODE}};
      r_an      <= {3{COMMON_ANODE}};
    end else begin
      if (r_refresh == DIV_LAST) begin
        r_refresh <= '0;
        r_digit   <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
      end else begin
        r_refresh <= r_refresh + 16'd1;
      end
      r_seg <= w_seg_hi ^ {7{COMMON_ANODE}};
      r_an  <= w_an_hi ^ {3{COMMON_ANODE}};
    end
  end

  assign bus.bcd       = r_bcd;
  assign bus.bcd_valid = r_bcd_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.seg       = r_seg;
  assign bus.an        = r_an;

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench for count_bcd_display: a time-based decimal model predicts
// conversions, strobes and the scanned display; a negedge monitor compares.
module tb_count_bcd_display;
  localparam int DIV = 4;
  localparam bit CA  = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_bcd_display_if bus ();

  count_bcd_display #(.REFRESH_DIV(DIV), .COMMON_ANODE(CA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int vectors     = 0;
  int miscompares = 0;

  // model state
  int          e = 0;
  int          model_val = 0;
  int          conv_val = 0;
  int          p, idx, dig;
  bit          lit;
  bit          started = 1'b0;
  logic [11:0] exp_q[$];
  logic [6:0]  exp_seg;
  logic [2:0]  exp_an;
  logic        exp_valid, exp_busy;

  // monitor state
  int          ncyc = 0;
  int          last_valid = -1;
  logic [11:0] exp_bcd;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic align;
    while (e % 10 != 0) tick(1);
  endtask

  // Reference model: conversions start every 10 edges after reset release,
  // the scan slot is (edge / DIV) mod 3, and the display shows the value
  // decimally with leading zeros suppressed.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      e         = 0;
      model_val = 0;
      exp_q.delete();
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_seg   = {7{CA}};
      exp_an    = {3{CA}};
      started   = 1'b1;
    end else begin
      p   = e % 10;
      idx = (e / DIV) % 3;
      case (idx)
        0:       begin lit = 1'b1;              dig = model_val % 10;        end
        1:       begin lit = (model_val >= 10);  dig = (model_val / 10) % 10; end
        default: begin lit = (model_val >= 100); dig = model_val / 100;       end
      endcase
      exp_seg   = (lit ? seg_tab[dig] : 7'h00) ^ {7{CA}};
      exp_an    = (lit ? 3'(1 << idx) : 3'b000) ^ {3{CA}};
      exp_valid = (p == 9);
      exp_busy  = (p != 9);
      if (p == 0) begin
        conv_val = int'(bus.count);
        exp_q.push_back(to_bcd(conv_val));
      end
      if (p == 9) model_val = conv_val;
      e++;
    end
  end

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (reset) last_valid = -1;
    if (started) begin
      chk("seg", bus.seg, exp_seg);
      chk("an", bus.an, exp_an);
      chk("busy", bus.busy, exp_busy);
      chk("bcd_valid", bus.bcd_valid, exp_valid);
      chk("bcd_hold", bus.bcd, to_bcd(model_val));
      if (bus.bcd_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", 1, 0);
        end else begin
          exp_bcd = exp_q.pop_front();
          chk("bcd_result", bus.bcd, exp_bcd);
        end
        if (last_valid >= 0) chk("valid_period", ncyc - last_valid, 10);
        last_valid = ncyc;
      end
    end
  end

  initial begin
    bus.count = 8'd0;
    reset     = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(30);

    bus.count = 8'd255;
    tick(40);

    bus.count = 8'd9;
    tick(40);

    // change on the 3rd shift cycle: the in-flight conversion keeps 100
    align();
    bus.count = 8'd100;
    tick(3);
    bus.count = 8'd37;
    tick(30);

    // reset mid-conversion aborts it
    align();
    bus.count = 8'd200;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(25);

    align();
    for (int v = 0; v < 256; v++) begin
      bus.count = 8'(v);
      tick(10);
    end

    repeat (40) begin
      bus.count = 8'($urandom_range(0, 255));
      tick(int'($urandom_range(1, 25)));
    end
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
Downstream display stage for the 8-bit up/down counter. Samples the counter's 8-bit binary value and converts it to 3-digit BCD with an iterative shift-add-3 (double-dabble) FSM. Drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking. Also exports the BCD value with a valid strobe for other consumers.

Parameters:
REFRESH_DIV, 16, clock cycles each digit stays lit before the scan advances (legal range 2..65535).
COMMON_ANODE, 1, 1 = segment and anode outputs active-low; 0 = active-high.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
count  input  8  binary value from the counter stage; unsigned, 0..255.
bcd  output  12  last converted value: {hundreds, tens, units}, 4 bits each.
bcd_valid  output  1  one-cycle pulse when bcd is updated.
busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}; polarity set by COMMON_ANODE.
an  output  3  digit enables: an[0]=units, an[1]=tens, an[2]=hundreds; polarity set by COMMON_ANODE.

Behaviour:
- Reset (clk edge with reset=1):
  - FSM goes to IDLE; shift register cleared.
  - bcd=0x000, bcd_valid=0, busy=0.
  - Refresh counter=0, digit index=0.
  - seg and an driven inactive (all off).
  - Reset mid-conversion aborts the conversion; the partial result is discarded.
- Conversion FSM, 20-bit shift register {bcd12, bin8}:
  - IDLE (1 cycle): load {12'h000, count}, set iteration counter to 0, go to SHIFT.
  - SHIFT (8 cycles): each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1. Increment the iteration counter; after the 8th shift go to DONE.
  - DONE (1 cycle): bcd <= shift register [19:8], bcd_valid=1 for this cycle only, then go to IDLE.
  - The FSM free-runs. One conversion every 10 cycles. Latency from the count sample edge to the bcd update edge is 9 edges.
  - count is sampled only in IDLE. Changes during SHIFT/DONE are ignored until the next IDLE.
  - Hundreds nibble never exceeds 2. Nibbles are never outside 0..9.
- Display scan:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps to 0.
  - On each wrap, digit index advances 0 -> 1 -> 2 -> 0.
  - seg and an are registered from the digit index and the current bcd. Outputs change one edge after the index changes.
  - Exactly one anode is active at a time, or none if the selected digit is blanked.
  - Blanking: hundreds blanked when hundreds=0; tens blanked when hundreds=0 and tens=0; units never blanked.
  - Blanked digit: an all inactive and seg all off for that slot. Scan timing is unchanged.
- Segment map (active-high form, {g..a}): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibble >9 drives blank (defensive).
- COMMON_ANODE=1 inverts both seg and an relative to the active-high form.
- The display shows the bcd register only, never intermediate shift-register contents.
- First cycle after reset deasserts: display slot 0 shows units "0" from bcd=0x000.

Test Plan:
- Reset for 3 cycles, then release with count=0 -> bcd=0x000, busy=0 during reset. First bcd_valid pulse 10 cycles after release with bcd=0x000. With COMMON_ANODE=1, units slot shows seg=7'h40, an=3'b110.
- count=255 held -> bcd=0x255 at the next DONE. Scan (REFRESH_DIV=4) shows 5, 5, 2 on an[0], an[1], an[2], each lit 4 cycles, period 12 cycles.
- count=9 held -> bcd=0x009. Tens and hundreds slots show an all inactive and seg all off; units slot shows active-high seg 6F.
- count changes 100 -> 37 on the 3rd SHIFT cycle -> that conversion yields 0x100. The next conversion yields 0x037; the hundreds slot is blanked.
- Assert reset during SHIFT with count=200 -> no bcd_valid pulse, bcd stays 0x000, FSM in IDLE. After release, next result is 0x200.
- Sweep count 0..255, one value per 10-cycle conversion, checking every bcd against a reference BCD -> all 256 match, and bcd_valid occurs exactly once per 10 cycles.
